// File: rtl/dct_pkg.sv
// Shared types and constants for the sequential 8x8 DCT engine.
package dct_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 8;

  typedef logic [15:0]   sample_t;
  typedef sample_t [7:0] row_t;

  typedef enum logic {
    ROW = 1'b0,
    COL = 1'b1
  } seq_state_t;

endpackage

// File: rtl/DCT_1D.sv
// 8-point integer 1-D DCT: y[k] = (sum_n C[k][n] * x[n]) >>> 3, wrapped to 16 bits.
// Element k of x/y sits at bits [16k+15:16k]; samples are two's complement.
module DCT_1D (
  input  logic [127:0] x,
  output logic [127:0] y
);

  localparam int C [8][8] = '{
    '{ 8,   8,   8,   8,   8,   8,   8,   8},
    '{12,  10,   6,   3,  -3,  -6, -10, -12},
    '{ 8,   4,  -4,  -8,  -8,  -4,   4,   8},
    '{10,  -3, -12,  -6,   6,  12,   3, -10},
    '{ 8,  -8,  -8,   8,   8,  -8,  -8,   8},
    '{ 6, -12,   3,  10, -10,  -3,  12,  -6},
    '{ 4,  -8,   8,  -4,  -4,   8,  -8,   4},
    '{ 3,  -6,  10, -12,  12, -10,   6,  -3}
  };

  // Matrix-vector product, one output coefficient per outer iteration.
  always_comb begin
    logic signed [31:0] acc;
    logic signed [15:0] xs;
    y   = '0;
    acc = '0;
    xs  = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      acc = '0;
      for (int unsigned n = 0; n < 8; n++) begin
        xs  = x[16*n +: 16];
        acc = acc + C[k][n] * 32'(xs);
      end
      y[16*k +: 16] = acc[18:3];
    end
  end

endmodule

// File: rtl/dct_tbuf.sv
// 8x8 transpose buffer: whole-row writes, combinational whole-column reads.
module dct_tbuf
  import dct_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [2:0] waddr,
  input  row_t       wdata,
  input  logic [2:0] raddr,
  output row_t       rdata
);

  row_t mem [N];

  // Row write; contents need no reset since every block rewrites all rows.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Column read: element r of the result comes from row r.
  always_comb begin
    rdata = '0;
    for (int unsigned r = 0; r < N; r++) begin
      rdata[r] = mem[r][raddr];
    end
  end

endmodule

// File: rtl/dct2d_seq.sv
// Time-multiplexed 8x8 2-D DCT: rows in through one DCT_1D into a transpose
// buffer, then columns back through the same DCT_1D to a registered output.
module dct2d_seq
  import dct_pkg::*;
#(
  parameter int unsigned DW  = 16,
  parameter int unsigned BCW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*DW-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*DW-1:0] out_data,
  output logic            out_last,
  output logic            busy,
  output logic [BCW-1:0]  blk_cnt
);

  if (DW != dct_pkg::DW) begin : g_dw_check
    $error("dct2d_seq: DW must be 16, the DCT_1D sample width");
  end

  seq_state_t state, state_d;
  logic [2:0] row_cnt;
  logic [2:0] col_cnt;
  logic       accept;
  logic       load_en;
  row_t       dct_in;
  row_t       dct_out;
  row_t       col_rd;

  DCT_1D u_dct (
    .x (dct_in),
    .y (dct_out)
  );

  dct_tbuf u_tbuf (
    .clk   (clk),
    .we    (accept),
    .waddr (row_cnt),
    .wdata (dct_out),
    .raddr (col_cnt),
    .rdata (col_rd)
  );

  // State register; abort returns to ROW like reset.
  always_ff @(posedge clk) begin
    if (rst || abort) state <= ROW;
    else              state <= state_d;
  end

  // Next state, handshake qualifiers and the shared DCT_1D input mux.
  always_comb begin
    state_d  = state;
    in_ready = (state == ROW) && !abort;
    accept   = in_valid && in_ready;
    load_en  = (state == COL) && (!out_valid || out_ready);
    busy     = (state == COL) || out_valid;
    dct_in   = (state == COL) ? col_rd : row_t'(in_data);
    case (state)
      ROW: if (accept && (row_cnt == 3'd7)) state_d = COL;
      COL: if (load_en && (col_cnt == 3'd7)) state_d = ROW;
      default: state_d = ROW;
    endcase
  end

  // Counters, output register and completed-block count.
  // row_cnt/col_cnt wrap 7->0 on their own, which is the end-of-phase reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt   <= '0;
      col_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      blk_cnt   <= '0;
    end else if (abort) begin
      row_cnt   <= '0;
      col_cnt   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready && out_last) blk_cnt <= blk_cnt + 1'b1;
      if (accept) row_cnt <= row_cnt + 3'd1;
      if (load_en) begin
        out_data  <= dct_out;
        out_last  <= (col_cnt == 3'd7);
        out_valid <= 1'b1;
        col_cnt   <= col_cnt + 3'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dct2d_seq.sv
// Self-checking bench for dct2d_seq: directed constant-block table, golden
// scoreboard on every output beat, and hand-written stall/abort/reset cases.
module tb_dct2d_seq;

  logic         clk;
  logic         rst;
  logic         abort;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;
  logic         busy;
  logic [15:0]  blk_cnt;

  dct2d_seq #(.DW(16), .BCW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .blk_cnt   (blk_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input string what);
    tests++;
    fails++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Reference 1-D transform (integer DCT matrix, >>>3, wrap to 16 bits).
  localparam int K [8][8] = '{
    '{ 8,   8,   8,   8,   8,   8,   8,   8},
    '{12,  10,   6,   3,  -3,  -6, -10, -12},
    '{ 8,   4,  -4,  -8,  -8,  -4,   4,   8},
    '{10,  -3, -12,  -6,   6,  12,   3, -10},
    '{ 8,  -8,  -8,   8,   8,  -8,  -8,   8},
    '{ 6, -12,   3,  10, -10,  -3,  12,  -6},
    '{ 4,  -8,   8,  -4,  -4,   8,  -8,   4},
    '{ 3,  -6,  10, -12,  12, -10,   6,  -3}
  };

  function automatic logic [127:0] dct1(input logic [127:0] x);
    logic [127:0] y;
    int s;
    y = '0;
    for (int k = 0; k < 8; k++) begin
      s = 0;
      for (int n = 0; n < 8; n++) s += K[k][n] * int'($signed(x[16*n +: 16]));
      s = s >>> 3;
      y[16*k +: 16] = s[15:0];
    end
    return y;
  endfunction

  function automatic void golden(input logic [127:0] rows [8], output logic [127:0] cols [8]);
    logic [127:0] r1 [8];
    logic [127:0] v;
    for (int r = 0; r < 8; r++) r1[r] = dct1(rows[r]);
    for (int c = 0; c < 8; c++) begin
      v = '0;
      for (int r = 0; r < 8; r++) v[16*r +: 16] = r1[r][16*c +: 16];
      cols[c] = dct1(v);
    end
  endfunction

  typedef struct {
    logic [127:0] data;
    logic         last;
    int           col;
  } beat_t;

  beat_t        exp_q [$];
  int           acc0_q [$];
  logic [127:0] blk_rows [8];
  logic [127:0] last_beats [8];
  int           row_idx     = 0;
  bit           col_phase   = 0;
  int           loads       = 0;
  bit           prev_valid  = 0;
  bit           prev_hs     = 0;
  bit           held        = 0;
  logic [127:0] held_data;
  logic         held_last;
  int           hold_checks = 0;
  int           blk_model   = 0;
  int           last_lat    = -1;
  bit           have_last   = 0;
  int           last_hs_cyc = 0;
  int           period_seen = 0;
  int           period_bad  = 0;

  // Scoreboard / protocol monitor, sampling on the falling edge.
  always @(negedge clk) begin
    logic [127:0] cols [8];
    beat_t b;
    bit new_beat;
    if (rst) begin
      exp_q.delete();
      acc0_q.delete();
      row_idx    = 0;
      col_phase  = 0;
      loads      = 0;
      prev_valid = 0;
      prev_hs    = 0;
      held       = 0;
      blk_model  = 0;
    end else begin
      if (held) begin
        hold_checks++;
        chk("hold_valid", 128'(out_valid), 128'(1'b1));
        chk("hold_data", out_data, held_data);
        chk("hold_last", 128'(out_last), 128'(held_last));
      end
      new_beat = out_valid && (!prev_valid || prev_hs);
      if (new_beat) begin
        loads++;
        if (loads == 1 && acc0_q.size() > 0) last_lat = cyc - acc0_q.pop_front();
        if (loads == 8) col_phase = 0;
      end
      chk("in_ready", 128'(in_ready), 128'(!col_phase && !abort));
      chk("busy", 128'(busy), 128'(col_phase || out_valid));
      chk("blk_cnt_track", 128'(blk_cnt), 128'(blk_model[15:0]));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          note_fail("beat_unexpected", $sformatf("got beat %h, expected none", out_data));
        end else begin
          b = exp_q.pop_front();
          chk($sformatf("beat_data_col%0d", b.col), out_data, b.data);
          chk($sformatf("beat_last_col%0d", b.col), 128'(out_last), 128'(b.last));
          last_beats[b.col] = out_data;
          if (out_last) begin
            blk_model++;
            if (have_last) begin
              period_seen++;
              if (cyc - last_hs_cyc != 16) period_bad++;
            end
            have_last   = 1;
            last_hs_cyc = cyc;
          end
        end
      end
      held       = out_valid && !out_ready;
      held_data  = out_data;
      held_last  = out_last;
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
      if (abort) begin
        exp_q.delete();
        acc0_q.delete();
        row_idx   = 0;
        col_phase = 0;
        loads     = 0;
        held      = 0;
      end else if (in_valid && in_ready) begin
        if (row_idx == 0) acc0_q.push_back(cyc);
        blk_rows[row_idx] = in_data;
        row_idx++;
        if (row_idx == 8) begin
          golden(blk_rows, cols);
          for (int c = 0; c < 8; c++) exp_q.push_back('{data: cols[c], last: (c == 7), col: c});
          row_idx   = 0;
          col_phase = 1;
          loads     = 0;
        end
      end
    end
  end

  // out_ready driver: random duty, with an optional 5-cycle stall on column 3.
  int rpct       = 100;
  bit stall_arm  = 0;
  int stall_left = 0;
  int stall_hits = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (stall_arm && out_valid && exp_q.size() > 0 && exp_q[0].col == 3) begin
        stall_arm  = 0;
        out_ready  = 1'b0;
        stall_left = 4;
        stall_hits++;
      end else begin
        out_ready = ($urandom_range(0, 99) < rpct);
      end
    end
  end

  // Called and returning at posedge+1; offers rows until n are accepted.
  task automatic send_rows(input logic [127:0] rows [8], input int n, input int vpct);
    int r = 0;
    int guard = 0;
    while (r < n) begin
      in_data  = rows[r];
      in_valid = ($urandom_range(0, 99) < vpct);
      @(negedge clk);
      if (in_valid && in_ready) r++;
      @(posedge clk);
      #1;
      guard++;
      if (guard > 3000) begin
        note_fail("send_timeout", $sformatf("got %0d rows accepted, expected %0d", r, n));
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 3000) note_fail("drain_timeout", $sformatf("got %0d beats pending, expected 0", exp_q.size()));
  endtask

  task automatic rand_block(output logic [127:0] rows [8]);
    for (int r = 0; r < 8; r++) rows[r] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  typedef struct {
    logic [15:0] v;
    logic [15:0] dc;
  } tv_t;

  tv_t tbl [6];

  initial begin
    logic [127:0] rows [8];
    logic [127:0] gcols [8];
    logic [127:0] ac;
    int exp_blk;
    int h0;
    int s0;
    int g;

    // Constant block v: row DCT gives 8v in element 0, column DCT gives 64v.
    tbl[0] = '{v: 16'h0000, dc: 16'h0000};
    tbl[1] = '{v: 16'h0001, dc: 16'h0040};
    tbl[2] = '{v: 16'hFFFE, dc: 16'hFF80};
    tbl[3] = '{v: 16'h0064, dc: 16'h1900};
    tbl[4] = '{v: 16'h01FF, dc: 16'h7FC0};
    tbl[5] = '{v: 16'h0200, dc: 16'h8000};

    rst      = 1'b1;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_out_last", 128'(out_last), 128'(1'b0));
    chk("rst_blk_cnt", 128'(blk_cnt), 128'h0);
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
    @(posedge clk);
    #1;

    // Zero block, continuous handshakes: first out_valid 9 cycles after first accept.
    for (int r = 0; r < 8; r++) rows[r] = '0;
    send_rows(rows, 8, 100);
    exp_blk = 1;
    wait_drain();
    chk("zero_latency", 128'(last_lat), 128'(9));
    chk("zero_blk_cnt", 128'(blk_cnt), 128'(exp_blk));

    // Directed constant-block table.
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < 8; r++) rows[r] = {8{tbl[t].v}};
      send_rows(rows, 8, 100);
      exp_blk++;
      wait_drain();
      chk($sformatf("tbl%0d_dc", t), 128'(last_beats[0][15:0]), 128'(tbl[t].dc));
      ac = last_beats[0] & ~(128'hFFFF);
      for (int c = 1; c < 8; c++) ac |= last_beats[c];
      chk($sformatf("tbl%0d_ac_zero", t), ac, 128'h0);
      chk($sformatf("tbl%0d_blk_cnt", t), 128'(blk_cnt), 128'(exp_blk));
    end

    // 20 random blocks back-to-back: 16-cycle block period.
    have_last   = 0;
    period_seen = 0;
    period_bad  = 0;
    for (int b = 0; b < 20; b++) begin
      rand_block(rows);
      send_rows(rows, 8, 100);
    end
    exp_blk += 20;
    wait_drain();
    chk("b2b_periods_seen", 128'(period_seen), 128'(19));
    chk("b2b_periods_bad", 128'(period_bad), 128'(0));
    chk("b2b_blk_cnt", 128'(blk_cnt), 128'(exp_blk));

    // Stall for 5 cycles while column 3 is presented.
    h0 = hold_checks;
    s0 = stall_hits;
    stall_arm = 1;
    rand_block(rows);
    send_rows(rows, 8, 100);
    exp_blk++;
    wait_drain();
    chk("stall_hit", 128'(stall_hits - s0), 128'(1));
    chk("stall_hold_cycles", 128'(hold_checks - h0), 128'(5));
    chk("stall_blk_cnt", 128'(blk_cnt), 128'(exp_blk));

    // Abort after 4 row accepts, then a full new block.
    rand_block(rows);
    send_rows(rows, 4, 100);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = rows[4];
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 128'(out_valid), 128'(1'b0));
    chk("abort_blk_cnt", 128'(blk_cnt), 128'(exp_blk));
    @(posedge clk);
    #1;
    rand_block(rows);
    golden(rows, gcols);
    send_rows(rows, 8, 100);
    exp_blk++;
    wait_drain();
    chk("abort_new_col0", last_beats[0], gcols[0]);
    chk("abort_new_col7", last_beats[7], gcols[7]);
    chk("abort_blk_cnt_after", 128'(blk_cnt), 128'(exp_blk));

    // Reset while column 4 is on the output (col_cnt = 5).
    rand_block(rows);
    send_rows(rows, 8, 100);
    g = 0;
    while (!(out_valid && exp_q.size() > 0 && exp_q[0].col == 4) && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 100) note_fail("rst_wait_col4", "got no column 4 beat, expected one within 100 cycles");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("midrst_blk_cnt", 128'(blk_cnt), 128'h0);
    @(posedge clk);
    #1;
    exp_blk = 0;
    rand_block(rows);
    golden(rows, gcols);
    send_rows(rows, 8, 100);
    exp_blk++;
    wait_drain();
    chk("midrst_next_col3", last_beats[3], gcols[3]);
    chk("midrst_next_blk_cnt", 128'(blk_cnt), 128'(exp_blk));

    // 50 blocks with random valid/ready duty between 30% and 70%.
    for (int b = 0; b < 50; b++) begin
      rpct = $urandom_range(30, 70);
      rand_block(rows);
      send_rows(rows, 8, $urandom_range(30, 70));
    end
    exp_blk += 50;
    wait_drain();
    rpct = 100;
    chk("duty_blk_cnt", 128'(blk_cnt), 128'(exp_blk));
    chk("duty_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
